// File: rtl/turn_if.sv
// Handshake and status bundle between the turn controller and its board datapath/player front end.
interface turn_if;
    localparam int unsigned COORD_W = 3;
    localparam int unsigned LIFE_W  = 4;

    logic               start;
    logic               fire;
    logic [COORD_W-1:0] sel_row;
    logic [COORD_W-1:0] sel_col;
    logic               attack_en;
    logic [COORD_W-1:0] attack_row;
    logic [COORD_W-1:0] attack_col;
    logic               attack_player;
    logic               attack_done;
    logic               attack_hit;
    logic [LIFE_W-1:0]  player_life;
    logic [LIFE_W-1:0]  pc_life;
    logic               turn;
    logic               invalid_sel;
    logic               game_over;
    logic               winner;

    // Player inputs and datapath responses come from the master side.
    modport master (
        output start, fire, sel_row, sel_col, attack_done, attack_hit,
        input  attack_en, attack_row, attack_col, attack_player,
               player_life, pc_life, turn, invalid_sel, game_over, winner
    );

    modport slave (
        input  start, fire, sel_row, sel_col, attack_done, attack_hit,
        output attack_en, attack_row, attack_col, attack_player,
               player_life, pc_life, turn, invalid_sel, game_over, winner
    );
endinterface

// File: rtl/turn_controller.sv
// Turn sequencing for a 5x5 naval battle: player move with timeout, LFSR-driven PC move,
// attack handshake with the board datapath, life bookkeeping and game-over detection.
module turn_controller #(
    parameter int unsigned LIFE_INIT      = 5,
    parameter int unsigned TIMEOUT_CYCLES = 750000000
) (
    input  logic   clk,
    input  logic   rst,
    turn_if.slave  bus
);
    localparam int unsigned COORD_W = 3;
    localparam int unsigned LIFE_W  = 4;
    localparam int unsigned CELLS   = 25;
    localparam int unsigned IDX_W   = 5;
    localparam int unsigned CNT_W   = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    typedef enum logic [2:0] {
        S_IDLE, S_P_WAIT, S_PC_SEL, S_ATTACK, S_A_WAIT, S_CHECK, S_GAMEOVER
    } state_e;

    state_e             state_q, state_d;
    logic [COORD_W-1:0] row_q, row_d, col_q, col_d;
    logic               player_q, player_d;
    logic               attack_en_q, attack_en_d;
    logic               invalid_q, invalid_d;
    logic               hit_q, hit_d;
    logic [LIFE_W-1:0]  player_life_q, player_life_d;
    logic [LIFE_W-1:0]  pc_life_q, pc_life_d;
    logic               turn_q, turn_d;
    logic               game_over_q, game_over_d;
    logic               winner_q, winner_d;
    logic [CELLS-1:0]   player_map_q, player_map_d;
    logic [CELLS-1:0]   pc_map_q, pc_map_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [IDX_W-1:0]   lfsr_q, lfsr_d;

    logic [IDX_W-1:0]   sel_idx_c;
    logic               sel_ok_c;
    logic [IDX_W-1:0]   pc_idx_c;
    logic [IDX_W-1:0]   atk_idx_c;
    logic [LIFE_W-1:0]  def_life_c;
    logic [LIFE_W-1:0]  dec_life_c;

    // Target decode; out-of-range coordinates never reach the bitmap lookup.
    always_comb begin
        sel_idx_c  = IDX_W'(IDX_W'(bus.sel_row) * IDX_W'(5) + IDX_W'(bus.sel_col));
        sel_ok_c   = 1'b0;
        if ((bus.sel_row <= COORD_W'(4)) && (bus.sel_col <= COORD_W'(4))) begin
            sel_ok_c = !player_map_q[sel_idx_c];
        end
        pc_idx_c   = lfsr_q - IDX_W'(1);
        atk_idx_c  = IDX_W'(IDX_W'(row_q) * IDX_W'(5) + IDX_W'(col_q));
        def_life_c = player_q ? pc_life_q : player_life_q;
        dec_life_c = (def_life_c == '0) ? '0 : def_life_c - LIFE_W'(1);
    end

    // Next-state and registered-output logic.
    always_comb begin
        state_d       = state_q;
        row_d         = row_q;
        col_d         = col_q;
        player_d      = player_q;
        attack_en_d   = 1'b0;
        invalid_d     = 1'b0;
        hit_d         = hit_q;
        player_life_d = player_life_q;
        pc_life_d     = pc_life_q;
        turn_d        = turn_q;
        game_over_d   = game_over_q;
        winner_d      = winner_q;
        player_map_d  = player_map_q;
        pc_map_d      = pc_map_q;
        cnt_d         = '0;
        lfsr_d        = {lfsr_q[3:0], lfsr_q[4] ^ lfsr_q[2]};

        case (state_q)
            S_IDLE, S_GAMEOVER: begin
                if (bus.start) begin
                    player_life_d = LIFE_W'(LIFE_INIT);
                    pc_life_d     = LIFE_W'(LIFE_INIT);
                    player_map_d  = '0;
                    pc_map_d      = '0;
                    turn_d        = 1'b1;
                    game_over_d   = 1'b0;
                    winner_d      = 1'b0;
                    state_d       = S_P_WAIT;
                end
            end
            S_P_WAIT: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (bus.fire && sel_ok_c) begin
                    row_d       = bus.sel_row;
                    col_d       = bus.sel_col;
                    player_d    = 1'b1;
                    attack_en_d = 1'b1;
                    state_d     = S_ATTACK;
                end else begin
                    invalid_d = bus.fire;
                    if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                        turn_d  = 1'b0;
                        state_d = S_PC_SEL;
                    end
                end
            end
            S_PC_SEL: begin
                if ((pc_idx_c < IDX_W'(CELLS)) && !pc_map_q[pc_idx_c]) begin
                    row_d       = COORD_W'(pc_idx_c / IDX_W'(5));
                    col_d       = COORD_W'(pc_idx_c % IDX_W'(5));
                    player_d    = 1'b0;
                    attack_en_d = 1'b1;
                    state_d     = S_ATTACK;
                end
            end
            S_ATTACK: begin
                if (player_q) player_map_d[atk_idx_c] = 1'b1;
                else          pc_map_d[atk_idx_c]     = 1'b1;
                state_d = S_A_WAIT;
            end
            S_A_WAIT: begin
                if (bus.attack_done) begin
                    hit_d   = bus.attack_hit;
                    state_d = S_CHECK;
                end
            end
            S_CHECK: begin
                if (hit_q) begin
                    if (player_q) pc_life_d     = dec_life_c;
                    else          player_life_d = dec_life_c;
                end
                if (hit_q && (dec_life_c == '0)) begin
                    game_over_d = 1'b1;
                    winner_d    = player_q;
                    state_d     = S_GAMEOVER;
                end else begin
                    turn_d  = !turn_q;
                    state_d = turn_q ? S_PC_SEL : S_P_WAIT;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= S_IDLE;
            row_q         <= '0;
            col_q         <= '0;
            player_q      <= 1'b0;
            attack_en_q   <= 1'b0;
            invalid_q     <= 1'b0;
            hit_q         <= 1'b0;
            player_life_q <= LIFE_W'(LIFE_INIT);
            pc_life_q     <= LIFE_W'(LIFE_INIT);
            turn_q        <= 1'b1;
            game_over_q   <= 1'b0;
            winner_q      <= 1'b0;
            player_map_q  <= '0;
            pc_map_q      <= '0;
            cnt_q         <= '0;
            lfsr_q        <= IDX_W'(1);
        end else begin
            state_q       <= state_d;
            row_q         <= row_d;
            col_q         <= col_d;
            player_q      <= player_d;
            attack_en_q   <= attack_en_d;
            invalid_q     <= invalid_d;
            hit_q         <= hit_d;
            player_life_q <= player_life_d;
            pc_life_q     <= pc_life_d;
            turn_q        <= turn_d;
            game_over_q   <= game_over_d;
            winner_q      <= winner_d;
            player_map_q  <= player_map_d;
            pc_map_q      <= pc_map_d;
            cnt_q         <= cnt_d;
            lfsr_q        <= lfsr_d;
        end
    end

    assign bus.attack_en     = attack_en_q;
    assign bus.attack_row    = row_q;
    assign bus.attack_col    = col_q;
    assign bus.attack_player = player_q;
    assign bus.player_life   = player_life_q;
    assign bus.pc_life       = pc_life_q;
    assign bus.turn          = turn_q;
    assign bus.invalid_sel   = invalid_q;
    assign bus.game_over     = game_over_q;
    assign bus.winner        = winner_q;
endmodule

// File: doc/turn_controller.md
TURN_CONTROLLER -- requirements
Module: turn_controller

Interface
REQ-001 Parameter LIFE_INIT, default 5, initial life of each side (ship cells on board), range 1..15.
REQ-002 Parameter TIMEOUT_CYCLES, default 750000000, player move time limit in clk cycles (15 s at 50 MHz).
REQ-003 clk  in  1  system clock, all logic on rising edge.
REQ-004 rst  in  1  synchronous active-high reset.
REQ-005 start  in  1  one-cycle pulse, starts a new game from IDLE or GAMEOVER.
REQ-006 fire  in  1  one-cycle pulse, player confirms target sel_row/sel_col.
REQ-007 sel_row, sel_col  in  3 each  player target, valid range 0..4.
REQ-008 attack_en  out  1  one-cycle pulse, launches one attack on the datapath.
REQ-009 attack_row, attack_col  out  3 each  target cell, stable from attack_en until attack_done.
REQ-010 attack_player  out  1  1 = player attacks the PC board, 0 = PC attacks the player board.
REQ-011 attack_done  in  1  datapath completion pulse; attack_hit is valid in the same cycle.
REQ-012 attack_hit  in  1  1 = targeted cell held a ship.
REQ-013 player_life, pc_life  out  4 each  remaining lives.
REQ-014 turn  out  1  1 = player's turn, 0 = PC's turn.
REQ-015 invalid_sel  out  1  one-cycle pulse, rejected fire.
REQ-016 game_over  out  1  level, game finished; winner  out  1  1 = player won.

Function
REQ-017 States: IDLE, P_WAIT, PC_SEL, ATTACK, A_WAIT, CHECK, GAMEOVER.
REQ-018 IDLE: start -> P_WAIT; lives load LIFE_INIT; both 25-bit attacked-cell bitmaps clear; turn=1.
REQ-019 P_WAIT: timeout counter clears on entry and increments each cycle.
REQ-020 P_WAIT, fire with row<=4, col<=4 and cell not yet attacked by player: latch target -> ATTACK, attack_player=1.
REQ-021 P_WAIT, fire with row>4, col>4 or cell already attacked: invalid_sel=1 for that cycle; remain in P_WAIT; counter not cleared.
REQ-022 P_WAIT, counter reaches TIMEOUT_CYCLES-1 with no valid fire: turn forfeited -> PC_SEL, turn=0, no attack issued.
REQ-023 P_WAIT, valid fire in the same cycle as timeout: the fire wins.
REQ-024 PC_SEL: 5-bit Fibonacci LFSR, x^5+x^3+1, seed 5'b00001, free-running every cycle from reset and never zero; idx = lfsr-1.
REQ-025 PC_SEL: when idx<25 and PC bitmap bit idx clear, target row=idx/5, col=idx%5 -> ATTACK, attack_player=0.
REQ-026 PC_SEL: otherwise stay; selection completes within 31 cycles while any cell is free.
REQ-027 ATTACK: attack_en=1 exactly one cycle; set the attacker's bitmap bit row*5+col; -> A_WAIT.
REQ-028 A_WAIT: attack_done is sampled only here, earliest one cycle after attack_en; on done register attack_hit -> CHECK.
REQ-029 A_WAIT: fire and start are ignored.
REQ-030 CHECK on hit: decrement the defender's life (pc_life when attack_player=1, else player_life), saturating at 0.
REQ-031 CHECK: decremented life = 0 -> GAMEOVER, game_over=1, winner=attack_player.
REQ-032 CHECK otherwise: toggle turn; turn=1 -> P_WAIT, turn=0 -> PC_SEL; miss leaves lives unchanged.
REQ-033 GAMEOVER: outputs frozen; start -> reinit as in REQ-018 -> P_WAIT.
REQ-034 fire outside P_WAIT is ignored, with no invalid_sel.

Reset
REQ-035 rst has priority over all inputs, including mid-attack.
REQ-036 rst -> state IDLE; attack_en=0; invalid_sel=0; game_over=0; winner=0; turn=1; lives=LIFE_INIT; bitmaps clear; attack_row/col/player=0; counter=0; LFSR=5'b00001.
REQ-037 attack_done arriving after a mid-attack rst is ignored.

Verification
REQ-038 start; fire (2,3); done with hit=1 two cycles later -> attack_en one cycle with row=2 col=3 player=1; pc_life 5->4; turn=0.
REQ-039 Player turn; fire (2,3) again after that cell was attacked -> invalid_sel one pulse; no attack_en; state stays P_WAIT.
REQ-040 Player turn; fire (5,0) -> invalid_sel one pulse; no attack_en.
REQ-041 TIMEOUT_CYCLES=8; no fire for 8 cycles in P_WAIT -> PC_SEL; turn=0; lives unchanged.
REQ-042 LIFE_INIT=1; player hits -> game_over=1, winner=1; further fire ignored; start -> lives=1, turn=1.
REQ-043 25 PC turns, every player fire invalid -> 25 distinct PC targets, each selected within 31 cycles.
REQ-044 rst asserted while in A_WAIT, then attack_done -> state IDLE; no life change.
